ntt_coeff_loader: RTL and testbench
===================================

Name: ntt_coeff_loader

Overview:
- Upstream feeder for the ntt core.
- Accepts a serial stream of 64-bit polynomial coefficients on a valid/ready handshake and reduces each to canonical form mod Q.
- Writes each reduced coefficient into a 64-entry buffer at its bit-reversed index.
- Presents the full vector on out_x with an out_valid/out_ready handshake, so the ntt core can start on a complete, ordered frame.

Parameters:
- N, 64, coefficients per frame (power of 2).
- LOG_N, 6, log2(N); address/counter width.
- W, 64, coefficient width in bits.
- Q, 64'hFFFF_FFFF_0000_0001, field modulus (Goldilocks).
- BITREV, 1, 1 = write at bitrev(index), 0 = natural order.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  loader can accept a coefficient.
- in_data  in  W  raw coefficient, 0..2^64-1.
- in_last  in  1  marks the final coefficient of a frame.
- out_x  out  N x W  unpacked array [0:N-1] of reduced coefficients.
- out_valid  out  1  out_x holds a complete frame.
- out_ready  in  1  ntt core consumes the frame.
- err_len  out  1  sticky frame-length error.
- err_clr  in  1  clears err_len.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=LOAD, cnt=0.
  - All out_x entries = 0, out_valid=0, err_len=0.
  - in_ready=0 while rst==0.
- Reduction (combinational):
  - red = (in_data >= Q) ? in_data - Q : in_data.
  - A single subtraction suffices because 2^64 < 2Q.
  - Result is always < Q.
- Write address: waddr = BITREV ? bit-reverse of cnt[LOG_N-1:0] : cnt.
- Handshake:
  - A beat transfers on the clk edge where in_valid && in_ready.
  - Likewise, a frame is consumed on the edge where out_valid && out_ready.
- State LOAD (in_ready=1, out_valid=0), on each beat:
  - out_x[waddr] <= red.
  - cnt==N-1 && in_last: state->HOLD, cnt->0.
  - cnt==N-1 && !in_last: err_len<=1, frame still completes, state->HOLD, cnt->0.
  - cnt<N-1 && in_last (early last): err_len<=1, frame dropped, cnt->0, stay LOAD. Partial entries are overwritten by the next frame.
  - cnt<N-1 && !in_last: cnt<=cnt+1.
  - No beat: no change.
- State HOLD (in_ready=0, out_valid=1):
  - out_x is held stable.
  - in_valid is ignored.
  - On out_ready: state->LOAD. out_valid=0 and in_ready=1 from the next cycle.
  - The HOLD->LOAD transition and a new beat cannot share a cycle, because in_ready=0 in HOLD.
- Latency:
  - The final beat accepted at edge t gives out_valid=1 after edge t.
  - Minimum frame period is N+1 cycles with out_ready tied high.
- err_len:
  - Set as above; cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-frame or in HOLD: everything returns to reset values next edge. Any partial frame is discarded.
- in_data in the same cycle as the final beat is written to the buffer before out_valid rises (no bypass).

Decomposition:
- Package ntt_pkg:
  - Constants N, LOG_N, W, Q.
  - typedef coeff_t = logic [W-1:0].
  - typedef state_t enum {LOAD, HOLD}.
  - Function bitrev(logic [LOG_N-1:0]).
- One sub-module, ntt_mod_reduce: combinational conditional subtract, in coeff_t, out coeff_t. It is reused later by the butterfly stage.

Test Plan:
- Basic frame: reset, stream k=0..63 (in_last on k=63), BITREV=1, out_ready=0.
  - out_valid=1 one cycle after the 64th beat.
  - out_x[0]=0, out_x[32]=1, out_x[24]=6, out_x[63]=63; err_len=0.
- Reduction:
  - in_data=Q gives 0.
  - Q+5 gives 5.
  - 2^64-1 gives 0xFFFF_FFFE.
  - Q-1 gives Q-1, unchanged.
  - Check at the corresponding bit-reversed slots.
- Backpressure: after a full frame hold out_ready=0 for 10 cycles with in_valid=1.
  - in_ready=0 and out_x unchanged throughout.
  - One-cycle out_ready pulse gives out_valid=0 and in_ready=1 next cycle.
  - The next frame loads correctly.
- Early last: in_last on the 10th beat.
  - err_len=1, out_valid stays 0.
  - A following 64-beat frame completes correctly.
  - err_len stays 1 until an err_clr pulse clears it.
- Mid-frame reset: drive rst=0 for one cycle after 30 beats.
  - out_valid=0 and all out_x=0 after the edge.
  - The next 64 beats produce a complete, correct frame.
- Gapped input: frame 0..63 with in_valid randomly deasserted about 30% of cycles, out_ready tied 1.
  - Identical out_x to the basic-frame test.
  - Back-to-back frames spaced N+1 cycles or more with no lost beats.

Source files
------------

// File: rtl/ntt_coeff_loader_pkg.sv
// Shared constants, types and helpers for the NTT coefficient path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ntt_pkg;

    localparam int N     = 64;
    localparam int LOG_N = 6;
    localparam int W     = 64;

    // Goldilocks prime 2^64 - 2^32 + 1.
    localparam logic [W-1:0] Q = 64'hFFFF_FFFF_0000_0001;

    typedef logic [W-1:0] coeff_t;

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Reverse the bit order of a buffer index.
    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG_N; i++) begin
            r[i] = a[LOG_N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_coeff_loader_if.sv
// Coefficient-in / frame-out bus between the stream source, the loader and the ntt core.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready per coefficient, out_valid/out_ready per frame.
// Ports: in_valid/in_ready/in_data/in_last (stream), out_x/out_valid/out_ready (frame),
//        err_len/err_clr (sticky length error). master = source/sink side, slave = loader.
interface ntt_coeff_loader_if;
    import ntt_pkg::*;

    logic   in_valid;
    logic   in_ready;
    coeff_t in_data;
    logic   in_last;
    coeff_t out_x [0:N-1];
    logic   out_valid;
    logic   out_ready;
    logic   err_len;
    logic   err_clr;

    modport master (
        output in_valid, in_data, in_last, out_ready, err_clr,
        input  in_ready, out_x, out_valid, err_len
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready, err_clr,
        output in_ready, out_x, out_valid, err_len
    );

endinterface

// File: rtl/ntt_mod_reduce.sv
// Canonicalise a 64-bit value mod Q with one conditional subtract (2^64 < 2Q).
// Latency: combinational.
// Backpressure: none.
// Ports: in_dat (raw coefficient), out_dat (reduced, always < Q).
module ntt_mod_reduce
    import ntt_pkg::*;
(
    input  coeff_t in_dat,
    output coeff_t out_dat
);

    assign out_dat = (in_dat >= Q) ? (in_dat - Q) : in_dat;

endmodule

// File: rtl/ntt_coeff_loader.sv
// Collect N reduced coefficients into a (bit-reversed) frame buffer and hand it to the ntt core.
// Latency: final beat accepted at edge t -> out_valid high after edge t.
// Backpressure: in_ready low while a complete frame waits in HOLD for out_ready.
// Ports: clk, rst (sync, active-low), bus (ntt_coeff_loader_if.slave).
module ntt_coeff_loader
    import ntt_pkg::*;
#(
    parameter bit BITREV = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    ntt_coeff_loader_if.slave bus
);

    state_t            state_q, state_d;
    logic [LOG_N-1:0]  cnt_q,   cnt_d;
    coeff_t            buf_q [N];
    coeff_t            buf_d [N];
    logic              err_len_q, err_len_d;

    coeff_t            red;
    logic [LOG_N-1:0]  waddr;
    logic              beat;
    logic              err_set;

    ntt_mod_reduce u_reduce (
        .in_dat  (bus.in_data),
        .out_dat (red)
    );

    assign waddr = BITREV ? bitrev(cnt_q) : cnt_q;

    // in_ready is gated by rst so the source sees no acceptance during reset.
    assign bus.in_ready  = rst && (state_q == LOAD);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.err_len   = err_len_q;
    assign bus.out_x     = buf_q;

    assign beat = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_set = 1'b0;

        case (state_q)
            LOAD: begin
                if (beat) begin
                    buf_d[waddr] = red;
                    if (cnt_q == LOG_N'(N-1)) begin
                        // A long frame still completes; only the flag records it.
                        state_d = HOLD;
                        cnt_d   = '0;
                        err_set = !bus.in_last;
                    end else if (bus.in_last) begin
                        // Short frame: drop it, stale slots get overwritten next frame.
                        cnt_d   = '0;
                        err_set = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + LOG_N'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

        // Set has priority over a simultaneous clear.
        err_len_d = err_len_q;
        if (bus.err_clr) err_len_d = 1'b0;
        if (err_set)     err_len_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            buf_q     <= '{default: '0};
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            err_len_q <= err_len_d;
        end
    end

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Self-checking bench for ntt_coeff_loader with a frame scoreboard.
// Latency: n/a.
// Backpressure: exercises out_ready hold-off and gapped in_valid.
module tb_ntt_coeff_loader;
    import ntt_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ntt_coeff_loader_if bus ();

    ntt_coeff_loader #(.BITREV(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: one entry per out_x slot, N entries per expected frame.
    coeff_t exp_q [$];
    coeff_t mdl_buf [N];
    coeff_t last_frame [N];
    int     mdl_cnt = 0;

    int     cyc = 0;
    int     frames = 0;
    int     last_rise = -1;
    logic   prev_vld = 1'b0;
    logic   chk_period = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic coeff_t ref_red(input coeff_t d);
        return (d >= Q) ? d - Q : d;
    endfunction

    function automatic logic [LOG_N-1:0] ref_brev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] r;
        r = {<<{a}};
        return r;
    endfunction

    // Drive one beat; returns right after the accepting edge with in_valid still high.
    task automatic send(input coeff_t d, input logic last, input int gap_pct);
        int waited = 0;
        logic [LOG_N-1:0] a;
        while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("send_timeout", 64'd0, 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        a = mdl_cnt[LOG_N-1:0];
        mdl_buf[ref_brev(a)] = ref_red(d);
        if (mdl_cnt == N-1) begin
            for (int i = 0; i < N; i++) exp_q.push_back(mdl_buf[i]);
            mdl_cnt = 0;
        end else if (last) begin
            mdl_cnt = 0;
        end else begin
            mdl_cnt++;
        end
    endtask

    task automatic wait_frame(input int target);
        int w = 0;
        while (frames < target && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("frame_wait", 64'(frames >= target), 64'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // Compare each newly presented frame against the scoreboard.
    always @(negedge clk) begin
        if (bus.out_valid && !prev_vld) begin
            frames++;
            if (chk_period && last_rise >= 0)
                check("frame_period", 64'((cyc - last_rise) >= N + 1), 64'd1);
            last_rise = cyc;
            if (exp_q.size() < N) begin
                check("sb_underflow", 64'(exp_q.size()), 64'(N));
            end else begin
                for (int i = 0; i < N; i++) begin
                    last_frame[i] = exp_q.pop_front();
                    check($sformatf("x[%0d]", i), bus.out_x[i], last_frame[i]);
                end
            end
        end
        prev_vld = bus.out_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        coeff_t d;
        int     f;

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        bus.err_clr   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_err_len",   64'(bus.err_len),   64'd0);
        for (int i = 0; i < N; i++) check($sformatf("rst_x[%0d]", i), bus.out_x[i], 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Basic frame, out_ready held low
        for (int k = 0; k < N; k++) begin
            if (k == N-1) check("pre_last_out_valid", 64'(bus.out_valid), 64'd0);
            send(coeff_t'(k), k == N-1, 0);
        end
        @(negedge clk);
        check("basic_out_valid", 64'(bus.out_valid), 64'd1);
        check("basic_x0",  bus.out_x[0],  64'd0);
        check("basic_x32", bus.out_x[32], 64'd1);
        check("basic_x24", bus.out_x[24], 64'd6);
        check("basic_x63", bus.out_x[63], 64'd63);
        check("basic_err", 64'(bus.err_len), 64'd0);

        // Backpressure: in_valid high, out_ready low for 10 cycles
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {$urandom, $urandom};
            bus.in_last  = 1'b0;
            @(negedge clk);
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            for (int i = 0; i < N; i++) check($sformatf("bp_x[%0d]", i), bus.out_x[i], last_frame[i]);
        end
        consume();
        check("pop_out_valid", 64'(bus.out_valid), 64'd0);
        check("pop_in_ready",  64'(bus.in_ready),  64'd1);

        // Reduction corners in beats 1..4 (slots 32, 16, 48, 8)
        for (int k = 0; k < N; k++) begin
            case (k)
                1:       d = Q;
                2:       d = Q + 64'd5;
                3:       d = '1;
                4:       d = Q - 64'd1;
                default: d = coeff_t'(k);
            endcase
            send(d, k == N-1, 0);
        end
        wait_frame(2);
        check("red_q",       bus.out_x[32], 64'd0);
        check("red_q5",      bus.out_x[16], 64'd5);
        check("red_max",     bus.out_x[48], 64'h0000_0000_FFFF_FFFE);
        check("red_qm1",     bus.out_x[8],  64'hFFFF_FFFF_0000_0000);
        check("red_err",     64'(bus.err_len), 64'd0);
        consume();

        // Early last on the 10th beat
        for (int k = 0; k < 10; k++) send(coeff_t'(k + 100), k == 9, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("early_err",       64'(bus.err_len),   64'd1);
        check("early_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (3) @(negedge clk);
        check("early_out_valid2", 64'(bus.out_valid), 64'd0);
        for (int k = 0; k < N; k++) send(coeff_t'(k + 200), k == N-1, 0);
        wait_frame(3);
        check("early_err_sticky", 64'(bus.err_len), 64'd1);
        consume();
        check("early_err_sticky2", 64'(bus.err_len), 64'd1);
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("err_cleared", 64'(bus.err_len), 64'd0);

        // Set and clear on the same edge: set wins
        send(64'd1, 1'b0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b1;
        send(64'd2, 1'b1, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b0;
        check("err_set_wins", 64'(bus.err_len), 64'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("err_cleared2", 64'(bus.err_len), 64'd0);

        // Mid-frame reset after 30 beats
        for (int k = 0; k < 30; k++) send(coeff_t'(k + 500), 1'b0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mrst_in_ready",  64'(bus.in_ready),  64'd0);
        for (int i = 0; i < N; i++) check($sformatf("mrst_x[%0d]", i), bus.out_x[i], 64'd0);
        rst = 1'b1;
        mdl_cnt = 0;
        for (int k = 0; k < N; k++) send(coeff_t'(k * 3 + 7), k == N-1, 0);
        wait_frame(4);
        consume();

        // Gapped input, out_ready tied high, two back-to-back frames
        bus.out_ready = 1'b1;
        chk_period    = 1'b1;
        f = frames;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) send(coeff_t'(k), k == N-1, 30);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_frame(f + 2);
        check("gap_frames", 64'(frames), 64'(f + 2));
        check("gap_x32", last_frame[32], 64'd1);
        check("gap_x24", last_frame[24], 64'd6);
        check("gap_x63", last_frame[63], 64'd63);
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("gap_err", 64'(bus.err_len), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
